// File: rtl/usb_pkg.sv
// Shared constants for the USB receive packet checker: PID codes, CRC
// parameters and the checker FSM encoding. USB_RX_SOF_EN enables SOF checking.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_DATA,
        ST_HSHK,
        ST_DROP
    } state_t;

    // The PID byte is decoded in the cycle it arrives, so routing is a pure function.
    function automatic state_t pid_route(input logic [7:0] b);
        state_t s;
        s = ST_DROP;
        if (b[7:4] == ~b[3:0]) begin
            case (b[3:0])
                PID_OUT, PID_IN, PID_SETUP:  s = ST_TOKEN;
`ifdef USB_RX_SOF_EN
                PID_SOF:                     s = ST_TOKEN;
`endif
                PID_DATA0, PID_DATA1:        s = ST_DATA;
                PID_ACK, PID_NAK, PID_STALL: s = ST_HSHK;
                default:                     s = ST_DROP;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/usb_crc_byte.sv
// One-byte CRC update, bits consumed LSB first, register MSB is the
// feedback tap. Purely combinational.
module usb_crc_byte #(
    parameter int             W    = 5,
    parameter logic [W-1:0]   POLY = '0
) (
    input  logic [W-1:0] crc_in,
    input  logic [7:0]   data,
    output logic [W-1:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[W-1] ^ data[i])
                crc_out = {crc_out[W-2:0], 1'b0} ^ POLY;
            else
                crc_out = {crc_out[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/usb_rx_packet_check.sv
// USB receive packet checker: PID/CRC5/CRC16 validation, token field
// extraction and CRC-stripped payload forwarding. USB_RX_SOF_EN enables SOF.
module usb_rx_packet_check
    import usb_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic        useClk,
    input  logic        reset,
    input  logic        checkData,
    input  logic [7:0]  parallelData,
    input  logic        detectEop,
    output logic        pktValid,
    output logic        pktError,
    output logic [3:0]  pid,
    output logic [6:0]  tokenAddr,
    output logic [3:0]  tokenEndp,
    output logic [10:0] frameNum,
    output logic        dataStrobe,
    output logic [7:0]  dataByte,
    output logic [6:0]  dataCount
);

    localparam int CW = $clog2(MAX_DATA_BYTES + 3);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DATA_BYTES + 2);
    localparam logic [CW-1:0] CNT_TWO = CW'(2);

    state_t        state, st_byte, st_next;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    crc5, crc5_n, crc5_upd;
    logic [15:0]   crc16, crc16_n, crc16_upd;
    logic [7:0]    tok0, tok0_n;
    logic [2:0]    tok1, tok1_n;
    logic [7:0]    dly0, dly0_n, dly1, dly1_n;
    logic [3:0]    cur_pid, pid_n;
    logic          silent, silent_n;
    logic          emit, verdict, ok;

    usb_crc_byte #(.W(5), .POLY(CRC5_POLY)) u_crc5 (
        .crc_in  (crc5),
        .data    (parallelData),
        .crc_out (crc5_upd)
    );

    usb_crc_byte #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
        .crc_in  (crc16),
        .data    (parallelData),
        .crc_out (crc16_upd)
    );

    always_comb begin
        st_byte  = state;
        cnt_n    = cnt;
        crc5_n   = crc5;
        crc16_n  = crc16;
        tok0_n   = tok0;
        tok1_n   = tok1;
        dly0_n   = dly0;
        dly1_n   = dly1;
        pid_n    = cur_pid;
        silent_n = silent;
        emit     = 1'b0;
        if (checkData) begin
            unique case (state)
                ST_IDLE: begin
                    st_byte  = pid_route(parallelData);
                    pid_n    = parallelData[3:0];
                    cnt_n    = '0;
                    crc5_n   = CRC5_INIT;
                    crc16_n  = CRC16_INIT;
                    dly0_n   = '0;
                    dly1_n   = '0;
                    silent_n = 1'b0;
`ifndef USB_RX_SOF_EN
                    silent_n = (parallelData == {~PID_SOF, PID_SOF});
`endif
                end
                ST_TOKEN: begin
                    if (cnt == CNT_TWO) begin
                        st_byte = ST_DROP;
                    end else begin
                        cnt_n  = cnt + 1'b1;
                        crc5_n = crc5_upd;
                        if (cnt == '0)
                            tok0_n = parallelData;
                        else
                            tok1_n = parallelData[2:0];
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_MAX) begin
                        st_byte = ST_DROP;
                    end else begin
                        cnt_n   = cnt + 1'b1;
                        crc16_n = crc16_upd;
                        dly0_n  = parallelData;
                        dly1_n  = dly0;
                        emit    = (cnt >= CNT_TWO);
                    end
                end
                ST_HSHK: st_byte = ST_DROP;
                default: ;
            endcase
        end

        // EOP is judged on the state after this cycle's byte, if any.
        st_next = st_byte;
        verdict = 1'b0;
        ok      = 1'b0;
        if (detectEop) begin
            st_next = ST_IDLE;
            case (st_byte)
                ST_TOKEN: begin
                    verdict = 1'b1;
                    ok = (cnt_n == CNT_TWO) && (crc5_n == CRC5_RESIDUAL);
                end
                ST_DATA: begin
                    verdict = 1'b1;
                    ok = (cnt_n >= CNT_TWO) && (crc16_n == CRC16_RESIDUAL);
                end
                ST_HSHK: begin
                    verdict = 1'b1;
                    ok      = 1'b1;
                end
                ST_DROP: verdict = !silent_n;
                default: ;
            endcase
        end
    end

    always_ff @(posedge useClk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            crc5       <= '0;
            crc16      <= '0;
            tok0       <= '0;
            tok1       <= '0;
            dly0       <= '0;
            dly1       <= '0;
            cur_pid    <= '0;
            silent     <= 1'b0;
            pktValid   <= 1'b0;
            pktError   <= 1'b0;
            pid        <= '0;
            tokenAddr  <= '0;
            tokenEndp  <= '0;
            dataStrobe <= 1'b0;
            dataByte   <= '0;
            dataCount  <= '0;
`ifdef USB_RX_SOF_EN
            frameNum   <= '0;
`endif
        end else begin
            state      <= st_next;
            cnt        <= cnt_n;
            crc5       <= crc5_n;
            crc16      <= crc16_n;
            tok0       <= tok0_n;
            tok1       <= tok1_n;
            dly0       <= dly0_n;
            dly1       <= dly1_n;
            cur_pid    <= pid_n;
            silent     <= silent_n;
            pktValid   <= verdict && ok;
            pktError   <= verdict && !ok;
            dataStrobe <= emit;
            if (emit)
                dataByte <= dly1;
            if (verdict)
                pid <= pid_n;
            if (verdict && ok && st_byte == ST_DATA)
                dataCount <= 7'(cnt_n - CNT_TWO);
            if (verdict && ok && st_byte == ST_TOKEN) begin
`ifdef USB_RX_SOF_EN
                if (pid_n == PID_SOF) begin
                    frameNum <= {tok1_n, tok0_n};
                end else begin
                    tokenAddr <= tok0_n[6:0];
                    tokenEndp <= {tok1_n, tok0_n[7]};
                end
`else
                tokenAddr <= tok0_n[6:0];
                tokenEndp <= {tok1_n, tok0_n[7]};
`endif
            end
        end
    end

`ifndef USB_RX_SOF_EN
    assign frameNum = '0;
`endif

endmodule

// File: tb/tb_usb_rx_packet_check.sv
// Self-checking bench for usb_rx_packet_check: scoreboard of expected
// payload bytes and verdicts, one task per scenario.
module tb_usb_rx_packet_check;

    logic        clk = 1'b0;
    logic        reset;
    logic        checkData;
    logic [7:0]  parallelData;
    logic        detectEop;
    logic        pktValid;
    logic        pktError;
    logic [3:0]  pid;
    logic [6:0]  tokenAddr;
    logic [3:0]  tokenEndp;
    logic [10:0] frameNum;
    logic        dataStrobe;
    logic [7:0]  dataByte;
    logic [6:0]  dataCount;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       ok;
        logic       care;
        logic [3:0] pid;
    } verdict_t;

    verdict_t   exp_v[$];
    logic [7:0] exp_b[$];
    logic [7:0] tx[$];
    logic [7:0] pl[$];
    verdict_t   mon_v;
    logic [7:0] mon_b;

    usb_rx_packet_check #(.MAX_DATA_BYTES(64)) dut (
        .useClk       (clk),
        .reset        (reset),
        .checkData    (checkData),
        .parallelData (parallelData),
        .detectEop    (detectEop),
        .pktValid     (pktValid),
        .pktError     (pktError),
        .pid          (pid),
        .tokenAddr    (tokenAddr),
        .tokenEndp    (tokenEndp),
        .frameNum     (frameNum),
        .dataStrobe   (dataStrobe),
        .dataByte     (dataByte),
        .dataCount    (dataCount)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (dataStrobe) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected got %02h want none", dataByte);
            end else begin
                mon_b = exp_b.pop_front();
                if (dataByte !== mon_b) begin
                    errors++;
                    $display("FAIL strobe_byte got %02h want %02h", dataByte, mon_b);
                end
            end
        end
        if (pktValid || pktError) begin
            checks++;
            if (exp_v.size() == 0) begin
                errors++;
                $display("FAIL verdict_unexpected got v=%b e=%b pid=%h want none",
                         pktValid, pktError, pid);
            end else begin
                mon_v = exp_v.pop_front();
                if (pktValid !== mon_v.ok || pktError !== !mon_v.ok ||
                    (mon_v.care && pid !== mon_v.pid)) begin
                    errors++;
                    $display("FAIL verdict got v=%b e=%b pid=%h want ok=%b pid=%h",
                             pktValid, pktError, pid, mon_v.ok, mon_v.pid);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

    function automatic logic [4:0] crc5_of(input logic [10:0] f);
        logic [4:0] c;
        logic       fb;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ f[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_of();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (pl[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ pl[k][i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic verdict_t vd(input logic o, input logic c, input logic [3:0] p);
        verdict_t v;
        v.ok   = o;
        v.care = c;
        v.pid  = p;
        return v;
    endfunction

    task automatic cyc(input logic cd, input logic [7:0] b, input logic eop);
        @(negedge clk);
        checkData    = cd;
        parallelData = b;
        detectEop    = eop;
    endtask

    task automatic send_pkt(input bit merge, input bit idle_after);
        for (int i = 0; i < tx.size(); i++)
            cyc(1'b1, tx[i], merge && (i == tx.size() - 1));
        if (!merge)
            cyc(1'b0, 8'h00, 1'b1);
        if (idle_after)
            cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic mk_token(input logic [3:0] p, input logic [10:0] f, input bit bad);
        logic [4:0] c;
        logic [7:0] b2;
        c = crc5_of(f);
        b2 = {~c[0], ~c[1], ~c[2], ~c[3], ~c[4], f[10:8]};
        if (bad)
            b2 = b2 ^ 8'h80;
        tx.delete();
        tx.push_back({~p, p});
        tx.push_back(f[7:0]);
        tx.push_back(b2);
    endtask

    task automatic mk_data(input logic [3:0] p, input bit bad);
        logic [15:0] c;
        logic [7:0]  c0, c1;
        c = crc16_of();
        for (int j = 0; j < 8; j++) begin
            c0[j] = ~c[15-j];
            c1[j] = ~c[7-j];
        end
        if (bad)
            c1 = c1 ^ 8'h04;
        tx.delete();
        tx.push_back({~p, p});
        foreach (pl[k])
            tx.push_back(pl[k]);
        tx.push_back(c0);
        tx.push_back(c1);
    endtask

    task automatic push_payload();
        foreach (pl[k])
            exp_b.push_back(pl[k]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_v.size() != 0 || exp_b.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_v.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d verdicts %0d bytes pending want 0",
                     exp_v.size(), exp_b.size());
            exp_v.delete();
            exp_b.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        checkData = 1'b0;
        parallelData = 8'h00;
        detectEop = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pktValid, pktError, dataStrobe} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got %b want 000", {pktValid, pktError, dataStrobe});
        end
        checks++;
        if (pid !== 4'h0 || dataByte !== 8'h00 || dataCount !== 7'h00) begin
            errors++;
            $display("FAIL reset_data got pid=%h b=%h n=%0d want 0", pid, dataByte, dataCount);
        end
        checks++;
        if (tokenAddr !== 7'h00 || tokenEndp !== 4'h0 || frameNum !== 11'h000) begin
            errors++;
            $display("FAIL reset_token got %h %h %h want 0", tokenAddr, tokenEndp, frameNum);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_token();
        tx = '{8'h69, 8'h00, 8'h10};
        exp_v.push_back(vd(1'b1, 1'b1, 4'h9));
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (pid !== 4'h9 || tokenAddr !== 7'h00 || tokenEndp !== 4'h0) begin
            errors++;
            $display("FAIL in_token got pid=%h a=%h e=%h want 9 0 0", pid, tokenAddr, tokenEndp);
        end
        mk_token(4'h1, {4'hB, 7'h3A}, 1'b0);
        exp_v.push_back(vd(1'b1, 1'b1, 4'h1));
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (tokenAddr !== 7'h3A || tokenEndp !== 4'hB) begin
            errors++;
            $display("FAIL out_token got a=%h e=%h want 3a b", tokenAddr, tokenEndp);
        end
        mk_token(4'hD, {4'h2, 7'h11}, 1'b1);
        exp_v.push_back(vd(1'b0, 1'b1, 4'hD));
        send_pkt(1'b0, 1'b1);
        mk_token(4'h9, {4'h1, 7'h05}, 1'b0);
        tx.push_back(8'h00);
        exp_v.push_back(vd(1'b0, 1'b1, 4'h9));
        send_pkt(1'b0, 1'b1);
        tx = '{8'h69, 8'h00};
        exp_v.push_back(vd(1'b0, 1'b1, 4'h9));
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (tokenAddr !== 7'h3A || tokenEndp !== 4'hB) begin
            errors++;
            $display("FAIL token_hold got a=%h e=%h want 3a b", tokenAddr, tokenEndp);
        end
    endtask

    task automatic test_setup_data(input bit bad);
        pl = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        mk_data(4'h3, bad);
        push_payload();
        exp_v.push_back(vd(!bad, 1'b1, 4'h3));
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (dataCount !== 7'd8) begin
            errors++;
            $display("FAIL setup_count bad=%0d got %0d want 8", bad, dataCount);
        end
    endtask

    task automatic test_data_bounds();
        pl.delete();
        mk_data(4'hB, 1'b0);
        exp_v.push_back(vd(1'b1, 1'b1, 4'hB));
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (dataCount !== 7'd0) begin
            errors++;
            $display("FAIL zero_len_count got %0d want 0", dataCount);
        end
        tx = '{8'h4B, 8'h00};
        exp_v.push_back(vd(1'b0, 1'b1, 4'hB));
        send_pkt(1'b0, 1'b1);
        pl.delete();
        for (int i = 0; i < 64; i++)
            pl.push_back(8'($urandom));
        mk_data(4'h3, 1'b0);
        push_payload();
        exp_v.push_back(vd(1'b1, 1'b1, 4'h3));
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (dataCount !== 7'd64) begin
            errors++;
            $display("FAIL max_len_count got %0d want 64", dataCount);
        end
        tx.delete();
        tx.push_back(8'hC3);
        for (int i = 0; i < 67; i++)
            tx.push_back(8'($urandom));
        for (int i = 1; i <= 64; i++)
            exp_b.push_back(tx[i]);
        exp_v.push_back(vd(1'b0, 1'b1, 4'h3));
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (dataCount !== 7'd64) begin
            errors++;
            $display("FAIL overflow_count got %0d want 64", dataCount);
        end
    endtask

    task automatic test_bad_pid();
        tx = '{8'hF0};
        exp_v.push_back(vd(1'b0, 1'b0, 4'h0));
        send_pkt(1'b0, 1'b1);
        tx = '{8'h55, 8'h11, 8'h22, 8'h33};
        exp_v.push_back(vd(1'b0, 1'b0, 4'h0));
        send_pkt(1'b0, 1'b1);
        tx = '{8'h5A, 8'h11, 8'h22, 8'h33};
        exp_v.push_back(vd(1'b0, 1'b1, 4'hA));
        send_pkt(1'b0, 1'b1);
        drain();
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        drain();
        checks++;
        if (pid !== 4'hA) begin
            errors++;
            $display("FAIL idle_eop_pid got %h want a", pid);
        end
    endtask

    task automatic test_handshake();
        exp_v.push_back(vd(1'b1, 1'b1, 4'h2));
        cyc(1'b1, 8'hD2, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (pktValid !== 1'b1 || pid !== 4'h2) begin
            errors++;
            $display("FAIL ack_latency got v=%b pid=%h want 1 2", pktValid, pid);
        end
        drain();
        tx = '{8'hD2, 8'h00};
        exp_v.push_back(vd(1'b0, 1'b1, 4'h2));
        send_pkt(1'b0, 1'b1);
        tx = '{8'h1E};
        exp_v.push_back(vd(1'b1, 1'b1, 4'hE));
        send_pkt(1'b0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        pl.delete();
        for (int i = 0; i < 5; i++)
            pl.push_back(8'($urandom));
        mk_data(4'hB, 1'b0);
        push_payload();
        exp_v.push_back(vd(1'b1, 1'b1, 4'hB));
        send_pkt(1'b1, 1'b0);
        mk_token(4'h9, {4'hF, 7'h7F}, 1'b0);
        exp_v.push_back(vd(1'b1, 1'b1, 4'h9));
        send_pkt(1'b1, 1'b1);
        drain();
        checks++;
        if (tokenAddr !== 7'h7F || tokenEndp !== 4'hF || dataCount !== 7'd5) begin
            errors++;
            $display("FAIL b2b got a=%h e=%h n=%0d want 7f f 5", tokenAddr, tokenEndp, dataCount);
        end
    endtask

    task automatic test_reset_abort();
        exp_b.push_back(8'hA1);
        cyc(1'b1, 8'h4B, 1'b0);
        cyc(1'b1, 8'hA1, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0);
        cyc(1'b1, 8'h5C, 1'b0);
        @(negedge clk);
        checkData = 1'b0;
        reset = 1'b1;
        checks++;
        if (dataStrobe !== 1'b1 || dataByte !== 8'hA1) begin
            errors++;
            $display("FAIL strobe_latency got s=%b b=%h want 1 a1", dataStrobe, dataByte);
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (tokenAddr !== 7'h00 || dataCount !== 7'd0 || pid !== 4'h0) begin
            errors++;
            $display("FAIL abort_clear got a=%h n=%0d pid=%h want 0", tokenAddr, dataCount, pid);
        end
        cyc(1'b0, 8'h00, 1'b1);
        tx = '{8'h69, 8'h00, 8'h10};
        exp_v.push_back(vd(1'b1, 1'b1, 4'h9));
        send_pkt(1'b0, 1'b1);
        drain();
    endtask

    task automatic test_sof();
`ifdef USB_RX_SOF_EN
        mk_token(4'h5, 11'h7FF, 1'b0);
        exp_v.push_back(vd(1'b1, 1'b1, 4'h5));
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (frameNum !== 11'h7FF || tokenAddr !== 7'h00) begin
            errors++;
            $display("FAIL sof_frame got %h a=%h want 7ff 0", frameNum, tokenAddr);
        end
        mk_token(4'h5, 11'h123, 1'b0);
        exp_v.push_back(vd(1'b1, 1'b1, 4'h5));
        send_pkt(1'b0, 1'b1);
        mk_token(4'h5, 11'h456, 1'b1);
        exp_v.push_back(vd(1'b0, 1'b1, 4'h5));
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (frameNum !== 11'h123) begin
            errors++;
            $display("FAIL sof_hold got %h want 123", frameNum);
        end
`else
        mk_token(4'h5, 11'h7FF, 1'b0);
        send_pkt(1'b0, 1'b1);
        drain();
        checks++;
        if (frameNum !== 11'h000 || pid !== 4'h9) begin
            errors++;
            $display("FAIL sof_disabled got f=%h pid=%h want 0 9", frameNum, pid);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_token();
        test_setup_data(1'b0);
        test_setup_data(1'b1);
        test_data_bounds();
        test_bad_pid();
        test_handshake();
        test_back_to_back();
        test_reset_abort();
        test_sof();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
